fp32_mac_pe: RTL
================

// Module: fp32_mac_pe
// PURPOSE
//  Systolic-array processing element, directly downstream of the FP_Multiplier combinational core.
//  Each cycle it multiplies a_in*b_in with an instantiated FP_Multiplier and registers the product.
//  It accumulates products into an FP32 running sum over one dot-product tile.
//  It forwards a_in/b_in to its east/south neighbours one cycle later.
// PARAMETERS
//  FP_W      32   operand/result width; only 32 is supported
//  EXP_BIAS  127  IEEE-754 single bias, used for overflow/underflow checks
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   a_in/b_in/in_first/in_last are valid this cycle
//  in_first   in   1   first product of a tile; replaces the accumulator instead of adding
//  in_last    in   1   last product of a tile; result is published
//  a_in       in   32  FP32 operand from west neighbour
//  b_in       in   32  FP32 operand from north neighbour
//  a_out      out  32  a_in delayed 1 cycle (to east)
//  b_out      out  32  b_in delayed 1 cycle (to south)
//  fwd_valid  out  1   in_valid delayed 1 cycle
//  fwd_first  out  1   in_first delayed 1 cycle
//  fwd_last   out  1   in_last delayed 1 cycle
//  res_valid  out  1   single-cycle pulse: res_data holds a finished tile sum
//  res_data   out  32  FP32 tile result; holds until next res_valid
// BEHAVIOUR
//  - Reset: every register and output is 0 (acc=+0, res_data=0, all valids/flags low).
//  - Stage 0->1 (edge t+1):
//    - a_out/b_out/fwd_* register their inputs every cycle, regardless of in_valid.
//    - If in_valid, P <= product, and p_valid/p_first/p_last <= 1/in_first/in_last; otherwise p_valid <= 0.
//  - Zero guard: if either operand's exponent field is 0, the product is +/-0 with sign = sa^sb.
//    This covers zeros and denormals flushed to zero, since the core always inserts the implicit 1.
//  - Product exponent overflow (biased > 254) gives +/-inf: exp=255, mantissa 0.
//    Underflow (biased < 1) gives +0.
//  - Stage 1->2 (edge t+2), when p_valid:
//    - acc <= p_first ? P : fp32_add(acc, P).
//    - If p_last: res_data <= that same new value, and res_valid <= 1.
//    - res_valid is 0 on every other cycle.
//  - Latency: input sample to res_valid is 2 cycles. Throughput is 1 product per cycle, with no stalls.
//  - Bubbles (in_valid=0): acc, res_data and P hold; in_first/in_last are ignored when in_valid=0.
//  - in_first & in_last in the same beat: the result is exactly P.
//  - Product without a preceding first (including after reset): it adds onto the current acc (0 after reset).
//  - Back-to-back tiles (last at t, first at t+1): legal. This gives two res_valid pulses on consecutive cycles with no loss.
//  - rst mid-tile: pipeline and acc clear on that edge. In-flight products are discarded and no res_valid is produced for them.
//  - Adder rules (fp32_add):
//    - Exponent field 0 is treated as zero.
//    - Align the smaller operand by right shift; an exponent difference > 25 returns the larger operand.
//    - Sign-magnitude add/sub; the result is truncated, not rounded.
//    - Normalise with a leading-zero count.
//    - An exact-zero result is +0 (0x00000000).
//    - Exponent overflow gives signed inf; underflow gives +0.
//    - inf inputs propagate as inf; NaN is unsupported (don't-care).
// STRUCTURE
//  - fp_defs.vh (shared header): FP32 field widths and positions, EXP_BIAS, `FP_POS_ZERO, `FP_INF_EXP, plus the existing `AddMode/`SubMode.
//  - Sub-module fp32_adder (combinational: A, B -> Sum) holds the alignment, add/sub, LZD and normalisation logic.
//  - This module instantiates FP_Multiplier and fp32_adder, plus the zero guard, pipeline registers and control.
// TESTING
//  1. Dot product:
//     - Drive 0x3F800000*0x40000000 (first), then 0x40400000*0x40000000 (last).
//     - Expect res_valid 2 cycles after last, res_data = 0x41000000 (8.0).
//  2. Zero guard: 0x00000000*0x40400000 with first&last -> res_data 0x00000000; also 0x80000000*0x3F800000 -> 0x80000000.
//  3. Bubbles: test 1 with 3 idle cycles between beats -> same 0x41000000, exactly one res_valid pulse, 2 cycles after last.
//  4. Cancellation: 0x40000000*0x3F800000 (first), 0xC0000000*0x3F800000 (last) -> res_data 0x00000000.
//  5. Back-to-back tiles:
//     - Tile A: 2.0 last at t. Tile B: first&last 0x3FC00000*0x40000000 at t+1.
//     - Expect res_valid at t+2 (0x40000000) and t+3 (0x40400000).
//  6. Reset mid-tile and pass-through:
//     - rst after a first beat; no res_valid follows.
//     - A last-only beat 0x3F800000*0x3F800000 -> 0x3F800000.
//     - a_out/b_out equal a_in/b_in delayed exactly 1 cycle throughout.

Source files
------------

// File: rtl/fp32_mac_pe_pkg.sv
// -----------------------------------------------------------------------------
// fp32_mac_pe_pkg
// Shared FP32 definitions for the MAC processing element:
//   - field layout (fp32_t), bias, +0 and inf exponent constants
//   - lzc26:    leading-zero count used by the adder normaliser
//   - fp32_mul: single-cycle FP32 multiply with zero guard, truncating
//               mantissa and inf/+0 on exponent overflow/underflow
// -----------------------------------------------------------------------------
package fp32_mac_pe_pkg;

  localparam int          FP32_W      = 32;
  localparam int          EXP_W       = 8;
  localparam int          MAN_W       = 23;
  localparam int          DEF_BIAS    = 127;
  localparam logic [7:0]  FP_INF_EXP  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Number of zeros above the most significant set bit (26 when v == 0).
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (v[i]) begin
        found = 1'b1;
      end else if (!found) begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  function automatic fp32_t fp32_mul(input fp32_t a, input fp32_t b, input int bias);
    fp32_t              r;
    logic [47:0]        prod;
    logic signed [10:0] e;
    r      = FP_POS_ZERO;
    r.sign = a.sign ^ b.sign;
    // Implicit 1 is always inserted, so denormals only survive via the zero guard.
    prod   = {1'b1, a.man} * {1'b1, b.man};
    e      = $signed({3'b000, a.exp}) + $signed({3'b000, b.exp}) - $signed(11'(bias))
             + (prod[47] ? 11'sd1 : 11'sd0);
    if (a.exp == '0 || b.exp == '0) begin
      r.exp = '0;
      r.man = '0;
    end else if (e > 11'sd254) begin
      r.exp = FP_INF_EXP;
      r.man = '0;
    end else if (e < 11'sd1) begin
      r = FP_POS_ZERO;
    end else begin
      r.exp = e[7:0];
      r.man = prod[47] ? prod[46:24] : prod[45:23];
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_mac_pe_adder.sv
// -----------------------------------------------------------------------------
// fp32_mac_pe_adder
// Combinational FP32 adder used for accumulation.
//   a, b : FP32 operands
//   sum  : a + b, truncated; exponent field 0 counts as zero, exact zero is +0,
//          overflow gives signed inf, underflow gives +0, inf propagates.
// -----------------------------------------------------------------------------
module fp32_mac_pe_adder
  import fp32_mac_pe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  fp32_t             fa, fb, op_lg, op_sm, r;
  logic [7:0]        diff;
  logic [25:0]       m_lg, m_sm, norm;
  logic [26:0]       mag;
  logic [4:0]        lz;
  logic [22:0]       man;
  logic signed [9:0] e;

  always_comb begin
    fa    = a;
    fb    = b;
    op_lg = fa;
    op_sm = fb;
    m_lg  = '0;
    m_sm  = '0;
    mag   = '0;
    lz    = '0;
    norm  = '0;
    man   = '0;
    e     = '0;
    r     = FP_POS_ZERO;

    // Order by magnitude so the subtraction below never goes negative.
    if ({fb.exp, fb.man} > {fa.exp, fa.man}) begin
      op_lg = fb;
      op_sm = fa;
    end
    diff = op_lg.exp - op_sm.exp;

    if (fa.exp == '0 && fb.exp == '0) begin
      r = FP_POS_ZERO;
    end else if (fa.exp == '0) begin
      r = fb;
    end else if (fb.exp == '0) begin
      r = fa;
    end else if (fa.exp == FP_INF_EXP) begin
      r = fa;
    end else if (fb.exp == FP_INF_EXP) begin
      r = fb;
    end else if (diff > 8'd25) begin
      r = op_lg;
    end else begin
      // Two guard bits below the mantissa keep a little precision through a subtract.
      m_lg = {1'b1, op_lg.man, 2'b00};
      m_sm = {1'b1, op_sm.man, 2'b00} >> diff;
      mag  = (op_lg.sign == op_sm.sign) ? ({1'b0, m_lg} + {1'b0, m_sm})
                                        : ({1'b0, m_lg} - {1'b0, m_sm});
      if (mag == '0) begin
        r = FP_POS_ZERO;
      end else begin
        if (mag[26]) begin
          e   = $signed({2'b00, op_lg.exp}) + 10'sd1;
          man = mag[25:3];
        end else begin
          lz   = lzc26(mag[25:0]);
          norm = mag[25:0] << lz;
          e    = $signed({2'b00, op_lg.exp}) - $signed({5'b00000, lz});
          man  = norm[24:2];
        end
        if (e > 10'sd254) begin
          r.sign = op_lg.sign;
          r.exp  = FP_INF_EXP;
          r.man  = '0;
        end else if (e < 10'sd1) begin
          r = FP_POS_ZERO;
        end else begin
          r.sign = op_lg.sign;
          r.exp  = e[7:0];
          r.man  = man;
        end
      end
    end
    sum = r;
  end

endmodule

// File: rtl/fp32_mac_pe.sv
// -----------------------------------------------------------------------------
// fp32_mac_pe
// Systolic-array MAC processing element. Stage 1 registers a_in*b_in, stage 2
// accumulates the product into a tile sum and publishes it on the last beat.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/first/last    beat qualifiers for a_in/b_in
//   a_in, b_in             FP32 operands from west / north
//   a_out, b_out, fwd_*    inputs delayed one cycle toward east / south
//   res_valid, res_data    one-cycle pulse with the finished tile sum (held)
// -----------------------------------------------------------------------------
module fp32_mac_pe
  import fp32_mac_pe_pkg::*;
#(
  parameter int FP_W     = 32,
  parameter int EXP_BIAS = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic            in_last,
  input  logic [FP_W-1:0] a_in,
  input  logic [FP_W-1:0] b_in,
  output logic [FP_W-1:0] a_out,
  output logic [FP_W-1:0] b_out,
  output logic            fwd_valid,
  output logic            fwd_first,
  output logic            fwd_last,
  output logic            res_valid,
  output logic [FP_W-1:0] res_data
);

  logic [FP_W-1:0] a_q, a_d, b_q, b_d;
  logic            fwd_valid_q, fwd_valid_d, fwd_first_q, fwd_first_d, fwd_last_q, fwd_last_d;
  logic [FP_W-1:0] p_q, p_d;
  logic            p_valid_q, p_valid_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [FP_W-1:0] acc_q, acc_d, res_data_q, res_data_d;
  logic            res_valid_q, res_valid_d;
  logic [FP_W-1:0] add_sum, acc_new;
  fp32_t           mul_res;

  fp32_mac_pe_adder u_adder (
    .a   (acc_q),
    .b   (p_q),
    .sum (add_sum)
  );

  always_comb begin
    mul_res     = fp32_mul(a_in, b_in, EXP_BIAS);

    a_d         = a_in;
    b_d         = b_in;
    fwd_valid_d = in_valid;
    fwd_first_d = in_first;
    fwd_last_d  = in_last;

    // Product register holds across bubbles; only the valid flag drops.
    p_d         = p_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    p_valid_d   = in_valid;
    if (in_valid) begin
      p_d       = mul_res;
      p_first_d = in_first;
      p_last_d  = in_last;
    end

    acc_new     = p_first_q ? p_q : add_sum;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    if (p_valid_q) begin
      acc_d = acc_new;
      if (p_last_q) begin
        res_data_d  = acc_new;
        res_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      fwd_valid_q <= 1'b0;
      fwd_first_q <= 1'b0;
      fwd_last_q  <= 1'b0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_first_q <= fwd_first_d;
      fwd_last_q  <= fwd_last_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_first = fwd_first_q;
  assign fwd_last  = fwd_last_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
